// File: rtl/port_serial_tx.sv
// Serial transmitter behind the CPU port pair: nibble-written byte -> async frame on txd.
// Optional even-parity bit between data and stop when PORT_SERIAL_TX_PARITY_EN is defined.
module port_serial_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] port_out,
    output logic [31:0] port_in,
    output logic        txd
);

`ifdef PORT_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_reg, state_next;
    logic        req_q_reg;
    logic        ack_reg;
    logic        holding_full_reg;
    logic        busy_reg;
    logic [7:0]  holding_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx_reg;
    logic [15:0] baud_cnt_reg;

    logic        baud_done;
    logic        pending;
    logic        accept;
    logic        move;
    logic        unused_port_bits;

    assign unused_port_bits = ^port_out[31:9];

    assign baud_done = (baud_cnt_reg == BAUD_LAST);
    assign pending   = (req_q_reg != ack_reg);
    // Move needs a full holding register and accept needs an empty one, so they never collide.
    assign move      = (state_reg == IDLE) && holding_full_reg;
    assign accept    = pending && !holding_full_reg;

    assign port_in = {21'd0, holding_full_reg, busy_reg, ack_reg, 8'd0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (holding_full_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_done && (bit_idx_reg == 3'd7)) begin
`ifdef PORT_SERIAL_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef PORT_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (state_reg)
            START:  txd = 1'b0;
            DATA:   txd = shift_reg[bit_idx_reg];
`ifdef PORT_SERIAL_TX_PARITY_EN
            PARITY: txd = ^shift_reg;
`endif
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q_reg        <= 1'b0;
            ack_reg          <= 1'b0;
            holding_full_reg <= 1'b0;
            holding_reg      <= 8'd0;
            shift_reg        <= 8'd0;
            busy_reg         <= 1'b0;
            bit_idx_reg      <= 3'd0;
            baud_cnt_reg     <= 16'd0;
        end else begin
            req_q_reg <= port_out[8];
            busy_reg  <= (state_reg != IDLE) | holding_full_reg;

            if (move) begin
                shift_reg        <= holding_reg;
                holding_full_reg <= 1'b0;
            end else if (accept) begin
                holding_reg      <= port_out[7:0];
                holding_full_reg <= 1'b1;
                ack_reg          <= req_q_reg;
            end

            // Held at zero in IDLE, so every frame's START begins from a fresh count.
            if ((state_reg == IDLE) || baud_done) begin
                baud_cnt_reg <= 16'd0;
            end else begin
                baud_cnt_reg <= baud_cnt_reg + 16'd1;
            end

            if (state_reg == DATA) begin
                if (baud_done) begin
                    bit_idx_reg <= bit_idx_reg + 3'd1;
                end
            end else begin
                bit_idx_reg <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_port_serial_tx.sv
// Bench for port_serial_tx at CLKS_PER_BIT=4: cycle-by-cycle model compare plus literal frame tables.
module tb_port_serial_tx;

    localparam int N = 4;
`ifdef PORT_SERIAL_TX_PARITY_EN
    localparam int  FRAME_BITS = 11;
    localparam bit  PAR        = 1'b1;
`else
    localparam int  FRAME_BITS = 10;
    localparam bit  PAR        = 1'b0;
`endif
    localparam int FRAME = FRAME_BITS * N;
    localparam int LOG_DEPTH = 4096;

    logic        clk;
    logic        rst;
    logic [31:0] port_out;
    logic [31:0] port_in;
    logic        txd;

    int n_checks;
    int n_fail;
    int cyc;
    logic txd_log [0:LOG_DEPTH-1];

    bit exp_a5 [0:10];
    bit exp_3c [0:10];
    bit exp_07 [0:10];

    port_serial_tx #(.CLKS_PER_BIT(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .port_out (port_out),
        .port_in  (port_in),
        .txd      (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string name, input int s, input bit exp_bits [0:10]);
        check({name, "_pre_idle"}, {31'd0, txd_log[s-1]}, 32'd1);
        for (int k = 0; k < FRAME_BITS; k++) begin
            for (int j = 0; j < N; j++) begin
                check($sformatf("%s_bit%0d", name, k), {31'd0, txd_log[s + k*N + j]}, {31'd0, exp_bits[k]});
            end
        end
        check({name, "_post_idle"}, {31'd0, txd_log[s + FRAME]}, 32'd1);
    endtask

    task automatic count_zeros(input int from, input int to, output int zeros);
        zeros = 0;
        for (int i = from; i <= to; i++) begin
            if (txd_log[i] !== 1'b1) zeros++;
        end
    endtask

    // Behavioural model: handshake rules plus frame position arithmetic.
    initial begin
        bit        m_valid;
        bit        m_req_q, m_ack, m_hold_full, m_busy_q;
        logic [7:0] m_hold, m_fbyte;
        int        m_fs;
        bit        active, mv, acc;
        logic      exp_txd;
        int        k;
        m_valid = 0; m_req_q = 0; m_ack = 0; m_hold_full = 0; m_busy_q = 0;
        m_hold = 8'd0; m_fbyte = 8'd0; m_fs = -1;
        forever begin
            @(negedge clk);
            if (cyc < LOG_DEPTH) txd_log[cyc] = txd;
            active = 0;
            if (m_valid) begin
                active  = (m_fs >= 0) && (cyc >= m_fs) && (cyc < m_fs + FRAME);
                exp_txd = 1'b1;
                if (active) begin
                    k = (cyc - m_fs) / N;
                    if (k == 0) exp_txd = 1'b0;
                    else if (k <= 8) exp_txd = m_fbyte[k-1];
                    else if (PAR && k == 9) exp_txd = ^m_fbyte;
                end
                check("model_txd", {31'd0, txd}, {31'd0, exp_txd});
                check("model_port_in", port_in, {21'd0, m_hold_full, m_busy_q, m_ack, 8'd0});
            end
            if (rst) begin
                m_valid = 1; m_req_q = 0; m_ack = 0; m_hold_full = 0; m_busy_q = 0; m_fs = -1;
            end else if (m_valid) begin
                mv  = !active && m_hold_full;
                acc = (m_req_q != m_ack) && !m_hold_full;
                m_busy_q = active || m_hold_full;
                if (mv) begin
                    m_fs = cyc + 1;
                    m_fbyte = m_hold;
                    m_hold_full = 0;
                end
                if (acc) begin
                    m_hold = port_out[7:0];
                    m_hold_full = 1;
                    m_ack = m_req_q;
                end
                m_req_q = port_out[8];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s0, u, s1, s2, s3, v, s4, rel, zeros, n, ack_cyc;
`ifdef PORT_SERIAL_TX_PARITY_EN
        exp_a5 = '{0,1,0,1,0,0,1,0,1,0,1};
        exp_3c = '{0,0,0,1,1,1,1,0,0,0,1};
        exp_07 = '{0,1,1,1,0,0,0,0,0,1,1};
`else
        exp_a5 = '{0,1,0,1,0,0,1,0,1,1,1};
        exp_3c = '{0,0,0,1,1,1,1,0,0,1,1};
        exp_07 = '{0,1,1,1,0,0,0,0,0,1,1};
`endif
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        port_out = 32'd0;

        // Reset and quiet line
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_port_in", port_in, 32'h0000_0000);
        check("reset_txd", {31'd0, txd}, 32'd1);
        rel = cyc;
        tick(100);
        count_zeros(rel, cyc - 1, zeros);
        check("reset_no_frame", zeros, 0);

        // Single byte 0xA5
        port_out = 32'h0000_00A5;
        tick(1);
        port_out = 32'h0000_01A5;
        t = cyc;
        $display("tx byte a5 req=1 at cycle %0d", t);
        s0 = t + 3;
        tick(1);
        check("ack_t_plus_1", {31'd0, port_in[8]}, 32'd0);
        tick(1);
        check("ack_t_plus_2", {31'd0, port_in[8]}, 32'd1);
        tick(20);
        check("busy_in_frame", {31'd0, port_in[9]}, 32'd1);
        tick(s0 + FRAME + 2 - cyc);
        check("busy_after_frame", {31'd0, port_in[9]}, 32'd0);
        check_frame("a5_single", s0, exp_a5);

        // Back-to-back 0xA5, 0x3C, then a third byte while holding is full
        port_out = 32'h0000_00A5;
        u  = cyc;
        $display("tx byte a5 req=0 at cycle %0d", u);
        s1 = u + 3;
        s2 = s1 + FRAME + 1;
        s3 = s2 + FRAME + 1;
        tick(2);
        check("ack_a5_b2b", {31'd0, port_in[8]}, 32'd0);
        port_out = 32'h0000_013C;
        $display("tx byte 3c req=1 at cycle %0d", cyc);
        n = 0;
        while (port_in[8] !== 1'b1 && n < 3) begin
            tick(1);
            n++;
        end
        check("ack_3c_within_3", {31'd0, port_in[8]}, 32'd1);
        tick(u + 10 - cyc);
        port_out = 32'h0000_0107;
        tick(1);
        port_out = 32'h0000_0007;
        $display("tx byte 07 req=0 at cycle %0d", cyc);
        tick(1);
        check("holding_full_flag", {31'd0, port_in[10]}, 32'd1);
        check("ack_held_while_full", {31'd0, port_in[8]}, 32'd1);
        n = 0;
        while (port_in[8] !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        ack_cyc = cyc;
        check("third_ack_cycle", ack_cyc, s2 + 1);
        tick(s3 + FRAME + 5 - cyc);
        check_frame("a5_b2b", s1, exp_a5);
        check_frame("3c_b2b", s2, exp_3c);
        check_frame("07_third", s3, exp_07);
        check("stop_to_start_gap", s2 - (s1 + FRAME - N), N + 1);

        // Reset in the middle of DATA bit 3 with a byte held
        port_out = 32'h0000_0081;
        tick(1);
        port_out = 32'h0000_0181;
        v  = cyc;
        s4 = v + 3;
        $display("tx byte 81 req=1 at cycle %0d", v);
        tick(6);
        port_out = 32'h0000_0142;
        tick(1);
        port_out = 32'h0000_0042;
        $display("tx byte 42 req=0 at cycle %0d", cyc);
        tick(8);
        check("held_before_reset", {31'd0, port_in[10]}, 32'd1);
        tick(s4 + 4*N + 1 - cyc);
        rst = 1'b1;
        port_out = 32'd0;
        tick(1);
        rst = 1'b0;
        check("midreset_txd", {31'd0, txd}, 32'd1);
        check("midreset_port_in", port_in, 32'h0000_0000);
        rel = cyc;
        tick(100);
        count_zeros(rel, cyc - 1, zeros);
        check("midreset_no_frame", zeros, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_serial_tx.md
Name: port_serial_tx

Overview:
- Peripheral on the far side of the CPU's 32-bit port_out/port_in pair. It turns bytes that the 4-bit core writes nibble-by-nibble into an asynchronous serial frame on txd.
- A toggle request/acknowledge handshake means the core never has to meet a timing window; it only polls port_in.
- A holding register plus a shift register give one byte of buffering behind the byte currently being sent.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535; baud counter is 16 bits.

Ports:
clk  input  1  system clock, same domain as the CPU core
rst  input  1  synchronous reset, active-high
port_out  input  32  CPU output port; [7:0] tx byte (nibbles 0,1), [8] request toggle, [31:9] ignored
port_in  output  32  CPU input port; [8] ack toggle, [9] busy, [10] holding full, all other bits 0
txd  output  1  serial line, idles high

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: txd=1, ack=0, busy=0, holding empty, state IDLE, req_q=0, baud counter 0, bit index 0.
- Reset mid-frame: txd=1 on the cycle after the reset edge; the shifted byte and any held byte are discarded.
- Reset values match the core's zeroed out registers, so req=ack=0 and no spurious transfer occurs.
- No synchronizer is used (same clock domain). req_q <= port_out[8] on every clock.
- Request pending: req_q != ack.
- Accept: when a request is pending and holding is empty:
  - holding <= port_out[7:0], sampled in the same cycle;
  - ack <= req_q.
- Accept latency: a toggle on port_out[8] visible in cycle t is reflected on port_in[8] in cycle t+2.
- Core contract: the data nibbles are stable before the req toggle and are held until ack matches. Data changing while a request is pending is undefined.
- Pending request with holding full: the request waits. ack does not change until holding drains.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If holding is full, move it to the shift register, clear holding, go to START. That is the cycle after accept, so START begins in cycle t+3.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd = shift[index], LSB first, each bit CLKS_PER_BIT cycles. Go to STOP after index 7.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles.
- Back-to-back frames: a full holding register at STOP exit is loaded the same cycle IDLE is entered. The next START follows with exactly one idle cycle, so txd stays high for CLKS_PER_BIT+1 cycles between frames.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. It is cleared on entry to START.
- busy = (state != IDLE) | holding_full. It is registered, so it is valid the cycle after any state or holding change.
- port_in[10] = holding_full.
- An accept and a holding-to-shifter move never happen in the same cycle. The move has priority, and the accept occurs on the next cycle.

Optional Feature:
- Macro: PORT_SERIAL_TX_PARITY_EN.
- Defined: state PARITY sits between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length is 11*CLKS_PER_BIT.
- Not defined: no PARITY state, 10-bit frame, and no parity logic is synthesized.

Test Plan:
- Reset check, CLKS_PER_BIT=4: hold rst 3 cycles, then release with port_out=0 -> txd=1, port_in=0x00000000, no frame for 100 cycles.
- Single byte: port_out=0x000000A5, then 0x000001A5 -> port_in[8]=1 two cycles later. txd sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. busy=1 during the frame and 0 afterwards.
- Back-to-back: send 0xA5, and right after ack send 0x3C (req back to 0) -> second ack within 3 cycles. The 0x3C frame starts 5 idle cycles after the 0xA5 frame begins its stop bit (stop bit of 4 cycles plus one idle cycle). Bits are 0,0,0,1,1,1,1,0,0,1.
- Holding full: toggle a third request while 0xA5 is shifting and 0x3C is held -> port_in[10]=1 and ack unchanged until 0x3C enters the shifter. Ack then toggles, and the third byte follows.
- Reset mid-frame: assert rst in DATA bit 3 -> txd=1 the next cycle, ack=0, held byte lost. With req returned to 0 by the bench, no further frame is sent.
- Parity (macro defined): send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1. Frame is 44 cycles at CLKS_PER_BIT=4.
